// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS-style front end: instruction field
// positions, field widths, datapath width defaults and opcodes.
// Latency: n/a (constants only). Backpressure: n/a.
package mips_pkg;

  // Default widths for the datapath, register addresses and the stall counter.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  // Field widths.
  localparam int OPCODE_W   = 6;
  localparam int FUNCT_W    = 6;
  localparam int IMM_W      = 16;

  // Field LSB positions within the instruction word.
  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  // Load-word opcode.
  localparam logic [OPCODE_W-1:0] OPCODE_LW = 6'h23;

endpackage : mips_pkg

// File: rtl/operand_bypass.sv
// Resolves one source operand: r0 -> 0, else EX/MEM bypass, else WB bypass,
// else register-file value. Latency: combinational. Backpressure: none.
// Ports: addr (operand register), rf_data (RF read value), mem_* / wb_*
// (bypass sources with write enables), data (resolved operand).
module operand_bypass
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] data
);

  logic mem_hit;
  logic wb_hit;

  // A write to r0 never produces a forward, even if its address matches.
  assign mem_hit = mem_wen && (mem_waddr != '0) && (mem_waddr == addr);
  assign wb_hit  = wb_wen  && (wb_waddr  != '0) && (wb_waddr  == addr);

  always_comb begin
    data = rf_data;
    if (addr == '0) begin
      // The register file does not hard-wire r0, so force it here.
      data = '0;
    end else if (mem_hit) begin
      data = mem_wdata;
    end else if (wb_hit) begin
      // The RF write lands at the edge, so a same-cycle read is still stale.
      data = wb_wdata;
    end
  end

endmodule : operand_bypass

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes IF/ID, reads and bypasses operands,
// detects load-use hazards and loads the ID/EX register.
// Latency: 1 cycle IF/ID -> ID/EX. Backpressure: stall_out holds IF/ID and
// PC on a load-use hazard while a bubble enters ID/EX; flush overrides stall.
// Ports: if_* (IF/ID input), flush, stall_out, rf_* (RF read ports),
// ex_load/ex_rd (hazard source), mem_*/wb_* (bypass), id_* (ID/EX register),
// stall_count (saturating load-use stall cycle counter).
module operand_fetch
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // IF/ID
  input  logic                if_valid,
  input  logic [DATA_W-1:0]   if_instr,
  input  logic                flush,
  output logic                stall_out,
  // Register file read ports
  output logic [ADDR_W-1:0]   rf_addr_1,
  output logic [ADDR_W-1:0]   rf_addr_2,
  input  logic [DATA_W-1:0]   rf_data_1,
  input  logic [DATA_W-1:0]   rf_data_2,
  // Hazard source in EX
  input  logic                ex_load,
  input  logic [ADDR_W-1:0]   ex_rd,
  // EX/MEM bypass
  input  logic                mem_wen,
  input  logic [ADDR_W-1:0]   mem_waddr,
  input  logic [DATA_W-1:0]   mem_wdata,
  // Write-back bypass
  input  logic                wb_wen,
  input  logic [ADDR_W-1:0]   wb_waddr,
  input  logic [DATA_W-1:0]   wb_wdata,
  // ID/EX register
  output logic                id_valid,
  output logic [DATA_W-1:0]   id_rs_data,
  output logic [DATA_W-1:0]   id_rt_data,
  output logic [ADDR_W-1:0]   id_rs,
  output logic [ADDR_W-1:0]   id_rt,
  output logic [ADDR_W-1:0]   id_rd,
  output logic [DATA_W-1:0]   id_imm,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [FUNCT_W-1:0]  id_funct,
  // Statistics
  output logic [CNT_W-1:0]    stall_count
);

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  logic [ADDR_W-1:0]   rs;
  logic [ADDR_W-1:0]   rt;
  logic [ADDR_W-1:0]   rd;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic [DATA_W-1:0]   imm;

  assign rs     = if_instr[RS_LSB +: ADDR_W];
  assign rt     = if_instr[RT_LSB +: ADDR_W];
  assign rd     = if_instr[RD_LSB +: ADDR_W];
  assign opcode = if_instr[OP_LSB +: OPCODE_W];
  assign funct  = if_instr[FUNCT_LSB +: FUNCT_W];
  assign imm    = {{(DATA_W-IMM_W){if_instr[IMM_LSB+IMM_W-1]}},
                   if_instr[IMM_LSB +: IMM_W]};

  assign rf_addr_1 = rs;
  assign rf_addr_2 = rt;

  // ------------------------------------------------------------------
  // Operand resolution
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  operand_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_rs (
    .addr      (rs),
    .rf_data   (rf_data_1),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .data      (rs_val)
  );

  operand_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_rt (
    .addr      (rt),
    .rf_data   (rf_data_2),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .data      (rt_val)
  );

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  logic load_use;
  logic capture;

  // The loaded value is not available until after MEM, so any reader of
  // ex_rd must wait one cycle. Not gated by rst: purely combinational.
  assign load_use  = if_valid && ex_load && (ex_rd != '0) &&
                     ((ex_rd == rs) || (ex_rd == rt));
  // A flushed instruction is dead, so holding IF/ID for it is pointless.
  assign stall_out = load_use && !flush;
  assign capture   = if_valid && !stall_out && !flush;

  // ------------------------------------------------------------------
  // ID/EX register and stall counter
  // ------------------------------------------------------------------
  logic                id_valid_q,   id_valid_d;
  logic [DATA_W-1:0]   id_rs_data_q, id_rs_data_d;
  logic [DATA_W-1:0]   id_rt_data_q, id_rt_data_d;
  logic [ADDR_W-1:0]   id_rs_q,      id_rs_d;
  logic [ADDR_W-1:0]   id_rt_q,      id_rt_d;
  logic [ADDR_W-1:0]   id_rd_q,      id_rd_d;
  logic [DATA_W-1:0]   id_imm_q,     id_imm_d;
  logic [OPCODE_W-1:0] id_opcode_q,  id_opcode_d;
  logic [FUNCT_W-1:0]  id_funct_q,   id_funct_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;

  always_comb begin
    // Bubble by default: stall, flush and invalid input all load zeros.
    id_valid_d   = 1'b0;
    id_rs_data_d = '0;
    id_rt_data_d = '0;
    id_rs_d      = '0;
    id_rt_d      = '0;
    id_rd_d      = '0;
    id_imm_d     = '0;
    id_opcode_d  = '0;
    id_funct_d   = '0;
    if (capture) begin
      id_valid_d   = 1'b1;
      id_rs_data_d = rs_val;
      id_rt_data_d = rt_val;
      id_rs_d      = rs;
      id_rt_d      = rt;
      id_rd_d      = rd;
      id_imm_d     = imm;
      id_opcode_d  = opcode;
      id_funct_d   = funct;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_out && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q    <= 1'b0;
      id_rs_data_q  <= '0;
      id_rt_data_q  <= '0;
      id_rs_q       <= '0;
      id_rt_q       <= '0;
      id_rd_q       <= '0;
      id_imm_q      <= '0;
      id_opcode_q   <= '0;
      id_funct_q    <= '0;
      stall_count_q <= '0;
    end else begin
      id_valid_q    <= id_valid_d;
      id_rs_data_q  <= id_rs_data_d;
      id_rt_data_q  <= id_rt_data_d;
      id_rs_q       <= id_rs_d;
      id_rt_q       <= id_rt_d;
      id_rd_q       <= id_rd_d;
      id_imm_q      <= id_imm_d;
      id_opcode_q   <= id_opcode_d;
      id_funct_q    <= id_funct_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_rs_data  = id_rs_data_q;
  assign id_rt_data  = id_rt_data_q;
  assign id_rs       = id_rs_q;
  assign id_rt       = id_rt_q;
  assign id_rd       = id_rd_q;
  assign id_imm      = id_imm_q;
  assign id_opcode   = id_opcode_q;
  assign id_funct    = id_funct_q;
  assign stall_count = stall_count_q;

endmodule : operand_fetch
